// File: rtl/branch_predict_tracker.sv
// Carries branch prediction and pattern index from IF through ID/EX to MEM, resolves at MEM.
// Optional perf counters enabled by defining BP_PERF_CNT_EN.
module branch_predict_tracker #(
  parameter int PATTERN_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    IF_valid,
  input  logic                    IF_prediction,
  input  logic [PATTERN_BITS-1:0] IF_pattern,
  input  logic                    MEM_is_branch,
  input  logic                    MEM_taken,
  output logic                    update,
  output logic                    branch_result,
  output logic [PATTERN_BITS-1:0] MEM_pattern_used,
  output logic                    mispredict
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]             branch_count,
  output logic [31:0]             mispredict_count
`endif
);

  logic                    r_id_vld;
  logic                    r_id_pred;
  logic [PATTERN_BITS-1:0] r_id_pat;
  logic                    r_ex_vld;
  logic                    r_ex_pred;
  logic [PATTERN_BITS-1:0] r_ex_pat;
  logic                    r_mem_vld;
  logic                    r_mem_pred;
  logic [PATTERN_BITS-1:0] r_mem_pat;

  logic w_resolve;
  logic w_mispredict;
  logic w_kill;

  assign w_resolve    = r_mem_vld & MEM_is_branch & ~stall;
  assign w_mispredict = w_resolve & (r_mem_pred != MEM_taken);
  assign w_kill       = flush | w_mispredict;

  assign update           = w_resolve;
  assign branch_result    = MEM_taken;
  assign MEM_pattern_used = r_mem_pat;
  assign mispredict       = w_mispredict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_vld   <= 1'b0;
      r_id_pred  <= 1'b0;
      r_id_pat   <= '0;
      r_ex_vld   <= 1'b0;
      r_ex_pred  <= 1'b0;
      r_ex_pat   <= '0;
      r_mem_vld  <= 1'b0;
      r_mem_pred <= 1'b0;
      r_mem_pat  <= '0;
    end else if (!stall) begin
      if (w_kill) begin
        // MEM instruction retires; everything younger becomes a bubble
        r_id_vld   <= 1'b0;
        r_id_pred  <= 1'b0;
        r_id_pat   <= '0;
        r_ex_vld   <= 1'b0;
        r_ex_pred  <= 1'b0;
        r_ex_pat   <= '0;
        r_mem_vld  <= 1'b0;
        r_mem_pred <= 1'b0;
        r_mem_pat  <= '0;
      end else begin
        r_id_vld   <= IF_valid;
        r_id_pred  <= IF_prediction;
        r_id_pat   <= IF_pattern;
        r_ex_vld   <= r_id_vld;
        r_ex_pred  <= r_id_pred;
        r_ex_pat   <= r_id_pat;
        r_mem_vld  <= r_ex_vld;
        r_mem_pred <= r_ex_pred;
        r_mem_pat  <= r_ex_pat;
      end
    end else if (flush) begin
      // Stalled flush: squash the younger entries, MEM waits to resolve
      r_id_vld  <= 1'b0;
      r_id_pred <= 1'b0;
      r_id_pat  <= '0;
      r_ex_vld  <= 1'b0;
      r_ex_pred <= 1'b0;
      r_ex_pat  <= '0;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_resolve && (r_branch_count != 32'hFFFF_FFFF))
        r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF))
        r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_branch_predict_tracker.sv
// Directed bench for branch_predict_tracker with an update scoreboard.
// Counter checks compile only when BP_PERF_CNT_EN is defined.
module tb_branch_predict_tracker;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       flush;
  logic       IF_valid;
  logic       IF_prediction;
  logic [3:0] IF_pattern;
  logic       MEM_is_branch;
  logic       MEM_taken;
  logic       update;
  logic       branch_result;
  logic [3:0] MEM_pattern_used;
  logic       mispredict;
`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  branch_predict_tracker #(.PATTERN_BITS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .IF_valid         (IF_valid),
    .IF_prediction    (IF_prediction),
    .IF_pattern       (IF_pattern),
    .MEM_is_branch    (MEM_is_branch),
    .MEM_taken        (MEM_taken),
    .update           (update),
    .branch_result    (branch_result),
    .MEM_pattern_used (MEM_pattern_used),
    .mispredict       (mispredict)
`ifdef BP_PERF_CNT_EN
    ,
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pat;
    logic       res;
  } sb_t;

  sb_t         sb[$];
  int          vectors;
  int          miscompares;
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] pat, input logic res);
    sb_t e;
    e.pat = pat;
    e.res = res;
    sb.push_back(e);
  endtask

  // Drive one cycle at the falling edge, check the combinational outputs, let the rising edge clock it.
  task automatic step(input logic ifv, input logic pred, input logic [3:0] pat,
                      input logic st, input logic fl, input logic br, input logic tk,
                      input logic eu, input logic em);
    sb_t e;
    @(negedge clk);
    IF_valid      = ifv;
    IF_prediction = pred;
    IF_pattern    = pat;
    stall         = st;
    flush         = fl;
    MEM_is_branch = br;
    MEM_taken     = tk;
    #1;
    chk("update", {31'd0, update}, {31'd0, eu});
    chk("mispredict", {31'd0, mispredict}, {31'd0, em});
    if (update === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_update", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("MEM_pattern_used", {28'd0, MEM_pattern_used}, {28'd0, e.pat});
        chk("branch_result", {31'd0, branch_result}, {31'd0, e.res});
      end
    end
    if (eu && exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 32'd1;
    if (em && exp_mc != 32'hFFFF_FFFF) exp_mc = exp_mc + 32'd1;
  endtask

  task automatic idle(input int n, input logic st, input logic br, input logic tk);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, st, 1'b0, br, tk, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_bc      = '0;
    exp_mc      = '0;

    // Reset state, with live-looking inputs pushing against it
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    IF_valid = 1'b1; IF_prediction = 1'b1; IF_pattern = 4'hF;
    MEM_is_branch = 1'b1; MEM_taken = 1'b1;
    #3;
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_pattern", {28'd0, MEM_pattern_used}, 32'd0);
    chk("rst_branch_result_hi", {31'd0, branch_result}, 32'd1);
    MEM_taken = 1'b0;
    #1;
    chk("rst_branch_result_lo", {31'd0, branch_result}, 32'd0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1;
    chk("rst_hold_update", {31'd0, update}, 32'd0);
    chk("rst_hold_pattern", {28'd0, MEM_pattern_used}, 32'd0);
    @(negedge clk);
    IF_valid = 1'b0; IF_prediction = 1'b0; IF_pattern = 4'h0; MEM_is_branch = 1'b0;
    rst = 1'b0;

    // Correct prediction: one update, no mispredict
    push(4'hA, 1'b1);
    step(1, 1, 4'hA, 0, 0, 0, 0, 0, 0);
    idle(2, 1'b0, 1'b1, 1'b1);
    step(0, 0, 4'h0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 4'h0, 0, 0, 1, 1, 0, 0);

    // Mispredict squashes ID/EX and the IF instruction
    push(4'h5, 1'b1);
    step(1, 0, 4'h5, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'h6, 0, 0, 1, 1, 0, 0);
    step(1, 1, 4'h7, 0, 0, 1, 1, 0, 0);
    step(1, 1, 4'h8, 0, 0, 1, 1, 1, 1);
    idle(3, 1'b0, 1'b1, 1'b1);

    // Stall at MEM: no update while held, single pulse on release
    push(4'hC, 1'b0);
    step(1, 1, 4'hC, 0, 0, 0, 0, 0, 0);
    idle(2, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1, 1'b1, 1'b0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 4'h0, 0, 0, 1, 0, 0, 0);

    // Flush under stall: ID/EX cleared, MEM branch resolves after stall drops
    push(4'h1, 1'b0);
    step(1, 0, 4'h1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 4'h2, 0, 0, 0, 0, 0, 0);
    step(1, 0, 4'h3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 4'h0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 1, 0);
    idle(3, 1'b0, 1'b1, 1'b0);

    // Simultaneous flush and mispredict: single squash, update still fires
    push(4'h9, 1'b1);
    step(1, 0, 4'h9, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'h4, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'h4, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 1, 1, 1, 1);
    idle(3, 1'b0, 1'b1, 1'b1);

    // Valid non-branch in MEM is ignored; branch right behind it resolves
    step(1, 1, 4'hF, 0, 0, 0, 0, 0, 0);
    push(4'hE, 1'b0);
    step(1, 0, 4'hE, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 1, 0);

    // Flush alone retires MEM and squashes the younger entry
    push(4'h3, 1'b1);
    step(1, 1, 4'h3, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'h2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 1, 1, 1, 0);
    idle(3, 1'b0, 1'b1, 1'b1);

`ifdef BP_PERF_CNT_EN
    #1;
    chk("branch_count", branch_count, exp_bc);
    chk("mispredict_count", mispredict_count, exp_mc);
`endif

    // Reset mid-flight with three valid branches in the pipe
    step(1, 1, 4'h1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'h2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'h3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    IF_valid = 1'b0; MEM_is_branch = 1'b1; MEM_taken = 1'b0;
    #1;
    chk("pre_rst_update", {31'd0, update}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_update", {31'd0, update}, 32'd0);
    chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("midrst_pattern", {28'd0, MEM_pattern_used}, 32'd0);
    exp_bc = '0;
    exp_mc = '0;
`ifdef BP_PERF_CNT_EN
    chk("midrst_branch_count", branch_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(4, 1'b0, 1'b1, 1'b0);
    push(4'h6, 1'b0);
    step(1, 0, 4'h6, 0, 0, 0, 0, 0, 0);
    idle(2, 1'b0, 1'b1, 1'b0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 1, 0);

`ifdef BP_PERF_CNT_EN
    // Saturation of both counters
    @(negedge clk);
    force dut.r_branch_count = 32'hFFFF_FFFF;
    force dut.r_mispredict_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_branch_count;
    release dut.r_mispredict_count;
    exp_bc = 32'hFFFF_FFFF;
    exp_mc = 32'hFFFF_FFFF;
    push(4'h7, 1'b1);
    step(1, 0, 4'h7, 0, 0, 0, 0, 0, 0);
    idle(2, 1'b0, 1'b1, 1'b1);
    step(0, 0, 4'h0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    chk("sat_branch_count", branch_count, 32'hFFFF_FFFF);
    chk("sat_mispredict_count", mispredict_count, 32'hFFFF_FFFF);
`endif

    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
